// File: rtl/mt_range_sampler_if.sv
// Signal bundle for mt_range_sampler: generator pull port, bound load and sampled output stream.
// Handshakes: gen_trig consumes gen_num only in a cycle where gen_ready is high; an output beat
// transfers when out_valid && out_ready, and out_valid/out_data hold steady until that happens.
interface mt_range_sampler_if;
    logic [31:0] bound;
    logic        bound_load;
    logic [31:0] gen_num;
    logic        gen_ready;
    logic        gen_trig;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] reject_cnt;
    logic        state_dbg;

    modport master (
        input  bound, bound_load, gen_num, gen_ready, out_ready,
        output gen_trig, out_data, out_valid, reject_cnt, state_dbg
    );

    modport slave (
        output bound, bound_load, gen_num, gen_ready, out_ready,
        input  gen_trig, out_data, out_valid, reject_cnt, state_dbg
    );
endinterface

// File: rtl/mt_range_sampler.sv
// Pulls tempered words from the Mersenne-twister core, maps them into [0, bound) by
// mask-and-reject sampling and queues the results in a first-word fall-through FIFO.
module mt_range_sampler #(
    parameter int DEPTH = 4,
    parameter int GAP   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    mt_range_sampler_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [GW-1:0] GAP_LD   = GW'(GAP);
    localparam logic [GW-1:0] GAP_ONE  = 1;

    typedef enum logic {S_FETCH = 1'b0, S_WAIT = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [31:0]   bound_q, mask_q;
    logic [15:0]   rej_q;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count_q;
    logic          full, trig, accept, push, pop, reject;
    logic [31:0]   cand;

    // Smallest all-ones value covering b-1; b == 0 wraps to all ones, b == 1 gives zero.
    function automatic logic [31:0] mask_of(input logic [31:0] b);
        logic [31:0] m;
        m = b - 32'd1;
        m = m | (m >> 1);
        m = m | (m >> 2);
        m = m | (m >> 4);
        m = m | (m >> 8);
        m = m | (m >> 16);
        return m;
    endfunction

    assign full   = (count_q == FULL_CNT);
    assign cand   = bus.gen_num & mask_q;
    assign accept = (bound_q == 32'd0) || (cand < bound_q);
    // A load flushes the FIFO, so a word trigged in that cycle is consumed but dropped.
    assign push   = trig && accept && !bus.bound_load;
    assign reject = trig && !accept && !bus.bound_load;
    assign pop    = (count_q != '0) && bus.out_ready && !bus.bound_load;

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        trig    = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (rst_n && bus.gen_ready && !full && (gap_q == '0)) begin
                    trig    = 1'b1;
                    gap_d   = GAP_LD;
                    state_d = (GAP > 0) ? S_WAIT : S_FETCH;
                end
            end
            S_WAIT: begin
                gap_d = (gap_q == '0) ? '0 : gap_q - GAP_ONE;
                if (gap_q <= GAP_ONE) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            gap_q   <= '0;
            bound_q <= '0;
            mask_q  <= '1;
            rej_q   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            if (bus.bound_load) begin
                bound_q <= bus.bound;
                mask_q  <= mask_of(bus.bound);
                rej_q   <= '0;
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count_q <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
                case ({push, pop})
                    2'b10:   count_q <= count_q + CNT_ONE;
                    2'b01:   count_q <= count_q - CNT_ONE;
                    default: count_q <= count_q;
                endcase
                if (reject && (rej_q != 16'hFFFF)) rej_q <= rej_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= cand;
    end

    assign bus.gen_trig   = trig;
    assign bus.out_valid  = (count_q != '0);
    assign bus.out_data   = mem[rd_ptr];
    assign bus.reject_cnt = rej_q;
    assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_mt_range_sampler.sv
// Bench for mt_range_sampler: MT19937 model core, directed scenarios, and a scoreboard
// that queues expected outputs at each trig and checks them as the DUT delivers.
module tb_mt_range_sampler;
    localparam int DEPTH = 4;
    localparam int GAP   = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mt_range_sampler_if bus();

    mt_range_sampler #(.DEPTH(DEPTH), .GAP(GAP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] golden [8] = '{32'hD091BB5C, 32'd581869302, 32'd3890346734, 32'd3586334585,
                                32'd545404204, 32'd4161255391, 32'd3922919429, 32'd949333985};
    int trig_count = 0;
    int consumed   = 0;
    int pop_cnt    = 0;
    int gold_idx   = 0;
    bit ready_en   = 1'b0;
    bit strict     = 1'b0;
    bit golden_mode = 1'b0;
    logic [31:0] force_w [3];
    int force_n  = 0;
    int force_rd = 0;
    logic [31:0] last_out = '0;
    logic [15:0] exp_rej  = '0;

    logic [31:0] mt [624];
    int mti;
    logic [31:0] cur_word;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_mask(input logic [31:0] b);
        logic [31:0] m;
        if (b == 32'd0) return 32'hFFFFFFFF;
        m = 32'd0;
        while (m < b - 32'd1) m = (m << 1) | 32'd1;
        return m;
    endfunction

    function automatic void mt_init();
        mt[0] = 32'd5489;
        for (int i = 1; i < 624; i++)
            mt[i] = 32'd1812433253 * (mt[i-1] ^ (mt[i-1] >> 30)) + 32'(i);
        mti = 624;
    endfunction

    function automatic logic [31:0] mt_next();
        logic [31:0] y;
        if (mti >= 624) begin
            for (int i = 0; i < 624; i++) begin
                y = (mt[i] & 32'h80000000) | (mt[(i + 1) % 624] & 32'h7FFFFFFF);
                mt[i] = mt[(i + 397) % 624] ^ (y >> 1) ^ (y[0] ? 32'h9908B0DF : 32'h0);
            end
            mti = 0;
        end
        y = mt[mti];
        mti++;
        y = y ^ (y >> 11);
        y = y ^ ((y << 7) & 32'h9D2C5680);
        y = y ^ ((y << 15) & 32'hEFC60000);
        y = y ^ (y >> 18);
        return y;
    endfunction

    // Model core: advances one word per observed trig, shortly after the consuming edge.
    initial begin
        mt_init();
        cur_word = mt_next();
        bus.gen_num   = cur_word;
        bus.gen_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            while (consumed < trig_count) begin
                if (force_rd < force_n) force_rd++;
                else cur_word = mt_next();
                consumed++;
            end
            bus.gen_num   = (force_rd < force_n) ? force_w[force_rd] : cur_word;
            bus.gen_ready = ready_en;
        end
    end

    // Monitor and scoreboard, sampling mid-cycle.
    initial begin
        int ncyc;
        int last_trig;
        bit have_last;
        logic [31:0] mb, mm, cand, e;
        ncyc = 0; last_trig = 0; have_last = 1'b0; mb = '0; mm = '1;
        forever begin
            @(negedge clk);
            ncyc++;
            if (rst_n !== 1'b1) begin
                exp_q.delete();
                exp_rej = '0;
                mb = '0;
                mm = '1;
                have_last = 1'b0;
            end else begin
                if (bus.gen_trig === 1'b1) begin
                    trig_count++;
                    chk("trig_with_ready", 32'(bus.gen_ready), 32'd1);
                    chk("trig_not_full", 32'(exp_q.size() < DEPTH), 32'd1);
                    if (strict && have_last) chk("trig_spacing", 32'(ncyc - last_trig), 32'(GAP + 1));
                    have_last = 1'b1;
                    last_trig = ncyc;
                end
                if (bus.bound_load === 1'b1) begin
                    exp_q.delete();
                    mb = bus.bound;
                    mm = ref_mask(bus.bound);
                    exp_rej = '0;
                end else begin
                    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_out actual=%0h required=nothing at %0t", bus.out_data, $time);
                        end else begin
                            e = exp_q.pop_front();
                            chk("out_data", bus.out_data, e);
                        end
                        pop_cnt++;
                        last_out = bus.out_data;
                    end
                    if (bus.gen_trig === 1'b1) begin
                        cand = bus.gen_num & mm;
                        if (mb == 32'd0 || cand < mb) begin
                            if (golden_mode && gold_idx < 8) begin
                                exp_q.push_back(golden[gold_idx]);
                                gold_idx++;
                            end else begin
                                exp_q.push_back(cand);
                            end
                        end else if (exp_rej != 16'hFFFF) begin
                            exp_rej++;
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load_bound(input logic [31:0] b);
        bus.bound = b;
        bus.bound_load = 1'b1;
        tick();
        bus.bound_load = 1'b0;
    endtask

    task automatic wait_pops(input int n, input int budget, input string name);
        int target;
        int k;
        target = pop_cnt + n;
        k = 0;
        while (pop_cnt < target && k < budget) begin
            tick();
            k++;
        end
        chk(name, 32'(pop_cnt >= target), 32'd1);
    endtask

    task automatic wait_trigs(input int n, input int budget, input string name);
        int target;
        int k;
        target = trig_count + n;
        k = 0;
        while (trig_count < target && k < budget) begin
            tick();
            k++;
        end
        chk(name, 32'(trig_count >= target), 32'd1);
    endtask

    initial begin
        int snap;
        int k;
        rst_n = 1'b0;
        bus.bound = '0;
        bus.bound_load = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_gen_trig", 32'(bus.gen_trig), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_reject_cnt", 32'(bus.reject_cnt), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_state_fetch", 32'(bus.state_dbg), 32'd0);

        // 1: raw MT19937 stream with bound 0, strict trig spacing
        bus.out_ready = 1'b1;
        load_bound(32'd0);
        golden_mode = 1'b1;
        strict = 1'b1;
        ready_en = 1'b1;
        wait_pops(8, 60, "t1_raw_stream");
        strict = 1'b0;
        golden_mode = 1'b0;

        // 2: bound 1 forces every output to 0 with no rejects
        load_bound(32'd1);
        wait_pops(8, 60, "t2_bound1_stream");
        chk("t2_reject_cnt", 32'(bus.reject_cnt), 32'd0);

        // 3: bound 6, forced words 7, 6, 5
        ready_en = 1'b0;
        repeat (4) tick();
        load_bound(32'd6);
        force_w[0] = 32'd7;
        force_w[1] = 32'd6;
        force_w[2] = 32'd5;
        force_n = 3;
        tick();
        ready_en = 1'b1;
        wait_trigs(3, 30, "t3_forced_trigs");
        ready_en = 1'b0;
        repeat (3) tick();
        chk("t3_reject_cnt", 32'(bus.reject_cnt), 32'd2);
        chk("t3_last_out", last_out, 32'd5);
        chk("t3_queue_empty", 32'(exp_q.size()), 32'd0);

        // 4: downstream stall fills the FIFO, then drains in order
        bus.out_ready = 1'b0;
        load_bound(32'd0);
        snap = trig_count;
        ready_en = 1'b1;
        repeat (20) tick();
        chk("t4_trigs_in_stall", 32'(trig_count - snap), 32'(DEPTH));
        chk("t4_trig_low_full", 32'(bus.gen_trig), 32'd0);
        chk("t4_out_valid_held", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        wait_pops(DEPTH + 2, 40, "t4_drain");

        // 5: generator stall of 624 cycles mid-stream
        repeat (10) tick();
        ready_en = 1'b0;
        tick();
        snap = trig_count;
        repeat (624) tick();
        chk("t5_no_trig_in_stall", 32'(trig_count - snap), 32'd0);
        ready_en = 1'b1;
        wait_pops(5, 40, "t5_resume");

        // 6: bound_load coinciding with a trig while 3 entries are queued
        bus.out_ready = 1'b0;
        load_bound(32'd0);
        wait_trigs(3, 30, "t6_fill3");
        k = 0;
        while (bus.gen_trig !== 1'b1 && k < 10) begin
            tick();
            k++;
        end
        chk("t6_trig_seen", 32'(bus.gen_trig), 32'd1);
        chk("t6_entries_before_load", 32'(exp_q.size()), 32'd3);
        load_bound(32'd10);
        chk("t6_valid_after_load", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b1;
        wait_pops(1, 60, "t6_first_new");
        chk("t6_first_lt_bound", 32'(last_out < 32'd10), 32'd1);
        wait_pops(6, 150, "t6_more");
        chk("t6_reject_model", 32'(bus.reject_cnt), 32'(exp_rej));

        // 7: reset in the middle of operation
        bus.out_ready = 1'b0;
        repeat (8) tick();
        rst_n = 1'b0;
        #1;
        chk("t7_trig_low_in_reset", 32'(bus.gen_trig), 32'd0);
        tick();
        chk("t7_valid_cleared", 32'(bus.out_valid), 32'd0);
        chk("t7_reject_cleared", 32'(bus.reject_cnt), 32'd0);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        wait_pops(4, 40, "t7_after_reset");

        ready_en = 1'b0;
        repeat (10) tick();
        chk("final_out_valid", 32'(bus.out_valid), 32'd0);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
